instr_fetch_unit: RTL and testbench

Fetch/decode front end for the processor, directly upstream of the instruction ROM and the execution unit. A program counter drives the shared 16-bit address bus with the instruction-memory select in bits 15:12. The unit pulses nRead, captures the 32-bit word the ROM returns, and splits it into opcode, dest, src1 and src2. Each decoded instruction is handed to execution over a valid/ready handshake. Fetch halts on the stop opcode (FFh) or on an illegal opcode.

---
 rtl/instr_fetch_unit.sv | 182 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch/decode front end: reads ROM words over the shared address bus,
// splits them into fields and hands legal instructions to execution via valid/ready.
module instr_fetch_unit #(
    parameter logic [3:0] MEM_SEL  = 4'h2,
    parameter int         PC_WIDTH = 12,
    parameter int         DEPTH    = 12
) (
    input  logic                Clk,
    input  logic                nReset,
    input  logic                Start,
    output logic [15:0]         Address,
    output logic                nRead,
    input  logic [31:0]         InstrData,
    output logic [7:0]          Opcode,
    output logic [7:0]          Dest,
    output logic [7:0]          Src1,
    output logic [7:0]          Src2,
    output logic                IsMatrix,
    output logic                IsInt,
    output logic                InstrValid,
    input  logic                InstrReady,
    output logic [PC_WIDTH-1:0] Pc,
    output logic                Halted,
    output logic                IllegalOp
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] DECODE = 3'd2;
    localparam logic [2:0] ISSUE  = 3'd3;
    localparam logic [2:0] HALT   = 3'd4;

    localparam logic [PC_WIDTH-1:0] PC_ZERO = {PC_WIDTH{1'b0}};
    localparam logic [PC_WIDTH-1:0] PC_LAST = PC_WIDTH'(DEPTH - 1);
    localparam logic [7:0]          OP_STOP = 8'hFF;

    function automatic logic is_matrix_op(input logic [7:0] op);
        return (op <= 8'h07);
    endfunction

    function automatic logic is_int_op(input logic [7:0] op);
        return (op >= 8'h10) && (op <= 8'h13);
    endfunction

    logic [2:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] pc_next_s;
    logic [15:0]         addr_q, addr_d;
    logic                nread_q, nread_d;
    logic [31:0]         ir_q, ir_d;
    logic [7:0]          opcode_q, opcode_d;
    logic [7:0]          dest_q, dest_d;
    logic [7:0]          src1_q, src1_d;
    logic [7:0]          src2_q, src2_d;
    logic                is_matrix_q, is_matrix_d;
    logic                is_int_q, is_int_d;
    logic                valid_q, valid_d;
    logic                halted_q, halted_d;
    logic                illegal_q, illegal_d;

    assign pc_next_s = (pc_q == PC_LAST) ? PC_ZERO : pc_q + PC_WIDTH'(1);

    // Next-state and output decode for the fetch/decode/issue sequencer
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        nread_d     = 1'b1;
        ir_d        = ir_q;
        opcode_d    = opcode_q;
        dest_d      = dest_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        is_matrix_d = is_matrix_q;
        is_int_d    = is_int_q;
        valid_d     = valid_q;
        halted_d    = halted_q;
        illegal_d   = illegal_q;
        case (state_q)
            IDLE, HALT: begin
                if (Start) begin
                    state_d   = FETCH;
                    pc_d      = PC_ZERO;
                    addr_d    = {MEM_SEL, PC_ZERO};
                    nread_d   = 1'b0;
                    halted_d  = 1'b0;
                    illegal_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            FETCH: begin
                ir_d    = InstrData;
                state_d = DECODE;
            end
            DECODE: begin
                opcode_d    = ir_q[31:24];
                dest_d      = ir_q[23:16];
                src1_d      = ir_q[15:8];
                src2_d      = ir_q[7:0];
                is_matrix_d = is_matrix_op(ir_q[31:24]);
                is_int_d    = is_int_op(ir_q[31:24]);
                if (is_matrix_op(ir_q[31:24]) || is_int_op(ir_q[31:24])) begin
                    state_d = ISSUE;
                    valid_d = 1'b1;
                end else if (ir_q[31:24] == OP_STOP) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                end else begin
                    state_d   = HALT;
                    halted_d  = 1'b1;
                    illegal_d = 1'b1;
                end
            end
            ISSUE: begin
                // Transfer: the next fetch is launched on the same edge
                if (InstrReady) begin
                    valid_d = 1'b0;
                    pc_d    = pc_next_s;
                    addr_d  = {MEM_SEL, pc_next_s};
                    nread_d = 1'b0;
                    state_d = FETCH;
                end else begin
                    state_d = ISSUE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state_q     <= IDLE;
            pc_q        <= PC_ZERO;
            addr_q      <= 16'h0000;
            nread_q     <= 1'b1;
            ir_q        <= 32'h0000_0000;
            opcode_q    <= 8'h00;
            dest_q      <= 8'h00;
            src1_q      <= 8'h00;
            src2_q      <= 8'h00;
            is_matrix_q <= 1'b0;
            is_int_q    <= 1'b0;
            valid_q     <= 1'b0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            nread_q     <= nread_d;
            ir_q        <= ir_d;
            opcode_q    <= opcode_d;
            dest_q      <= dest_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            is_matrix_q <= is_matrix_d;
            is_int_q    <= is_int_d;
            valid_q     <= valid_d;
            halted_q    <= halted_d;
            illegal_q   <= illegal_d;
        end
    end

    assign Address    = addr_q;
    assign nRead      = nread_q;
    assign Opcode     = opcode_q;
    assign Dest       = dest_q;
    assign Src1       = src1_q;
    assign Src2       = src2_q;
    assign IsMatrix   = is_matrix_q;
    assign IsInt      = is_int_q;
    assign InstrValid = valid_q;
    assign Pc         = pc_q;
    assign Halted     = halted_q;
    assign IllegalOp  = illegal_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural ROM on the falling edge.
module tb_instr_fetch_unit;

    logic        Clk = 1'b0;
    logic        nReset;
    logic        Start;
    logic [15:0] Address;
    logic        nRead;
    logic [31:0] InstrData;
    logic [7:0]  Opcode, Dest, Src1, Src2;
    logic        IsMatrix, IsInt, InstrValid, InstrReady;
    logic [11:0] Pc;
    logic        Halted, IllegalOp;

    logic [31:0] rom [0:11];
    int          n_checks = 0;
    int          n_errors = 0;

    instr_fetch_unit dut (
        .Clk(Clk), .nReset(nReset), .Start(Start), .Address(Address), .nRead(nRead),
        .InstrData(InstrData), .Opcode(Opcode), .Dest(Dest), .Src1(Src1), .Src2(Src2),
        .IsMatrix(IsMatrix), .IsInt(IsInt), .InstrValid(InstrValid),
        .InstrReady(InstrReady), .Pc(Pc), .Halted(Halted), .IllegalOp(IllegalOp)
    );

    always #5 Clk = ~Clk;

    // ROM model: drives data on falling Clk while selected and read strobe low
    always @(negedge Clk) begin
        if (!nRead && Address[15:12] == 4'h2) begin
            if (Address[11:0] < 12'd12) InstrData <= rom[Address[3:0]];
            else                        InstrData <= 32'hDEAD_BEEF;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        nReset = 1'b0;
        Start  = 1'b0;
        tick();
        tick();
        nReset = 1'b1;
    endtask

    task automatic start_pulse();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    initial begin
        int  cyc;
        int  n_xfer;
        int  low_cnt;
        bit  seen_valid;
        bit  found;

        InstrReady = 1'b0;
        InstrData  = 32'h0000_0000;
        for (int i = 0; i < 12; i++) rom[i] = 32'h0000_0000;
        rom[0] = 32'h0302_0001;
        rom[1] = 32'h1010_0A0B;

        // Reset state
        do_reset();
        check_eq("rst_addr", 32'(Address), 32'h0000);
        check_eq("rst_nread", 32'(nRead), 32'h1);
        check_eq("rst_valid", 32'(InstrValid), 32'h0);
        check_eq("rst_pc", 32'(Pc), 32'h0);
        check_eq("rst_halt", 32'({Halted, IllegalOp, IsMatrix, IsInt}), 32'h0);
        check_eq("rst_fields", {Opcode, Dest, Src1, Src2}, 32'h0);

        // First fetch and decode
        start_pulse();
        check_eq("f0_addr", 32'(Address), 32'h2000);
        check_eq("f0_nread", 32'(nRead), 32'h0);
        tick();
        check_eq("f0_nread_hi", 32'(nRead), 32'h1);
        check_eq("f0_valid_early", 32'(InstrValid), 32'h0);
        tick();
        check_eq("i0_valid", 32'(InstrValid), 32'h1);
        check_eq("i0_fields", {Opcode, Dest, Src1, Src2}, 32'h0302_0001);
        check_eq("i0_class", 32'({IsMatrix, IsInt}), 32'h2);
        InstrReady = 1'b1;
        tick();
        InstrReady = 1'b0;
        check_eq("x0_valid", 32'(InstrValid), 32'h0);
        check_eq("x0_addr", 32'(Address), 32'h2001);
        check_eq("x0_nread", 32'(nRead), 32'h0);
        tick();
        tick();
        check_eq("i1_valid", 32'(InstrValid), 32'h1);
        check_eq("i1_fields", {Opcode, Dest, Src1, Src2}, 32'h1010_0A0B);
        check_eq("i1_class", 32'({IsMatrix, IsInt}), 32'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("stall_valid", 32'(InstrValid), 32'h1);
            check_eq("stall_fields", {Opcode, Dest, Src1, Src2}, 32'h1010_0A0B);
            check_eq("stall_pc", 32'(Pc), 32'h1);
            check_eq("stall_nread", 32'(nRead), 32'h1);
        end
        InstrReady = 1'b1;
        tick();
        InstrReady = 1'b0;
        check_eq("x1_valid", 32'(InstrValid), 32'h0);
        check_eq("x1_addr", 32'(Address), 32'h2002);
        check_eq("x1_pc", 32'(Pc), 32'h2);

        // Full program ending in stop
        for (int i = 0; i < 8; i++) rom[i] = {8'(i), 8'(i), 8'(i + 1), 8'(i + 2)};
        for (int i = 8; i < 11; i++) rom[i] = {8'(8 + i), 8'(i), 8'(i + 1), 8'(i + 2)};
        rom[11] = 32'hFF00_0000;
        do_reset();
        InstrReady = 1'b1;
        start_pulse();
        cyc = 0;
        n_xfer = 0;
        while (!Halted && cyc < 200) begin
            if (InstrValid) begin
                if (n_xfer < 12) check_eq("prog_word", {Opcode, Dest, Src1, Src2}, rom[n_xfer]);
                n_xfer++;
            end
            tick();
            cyc++;
        end
        check_eq("prog_halted", 32'(Halted), 32'h1);
        check_eq("prog_xfers", 32'(n_xfer), 32'd11);
        check_eq("prog_cycles", 32'(cyc), 32'd35);
        check_eq("prog_pc", 32'(Pc), 32'd11);
        check_eq("prog_illegal", 32'(IllegalOp), 32'h0);
        check_eq("prog_valid", 32'(InstrValid), 32'h0);
        low_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (!nRead || InstrValid) low_cnt++;
        end
        check_eq("halt_quiet", 32'(low_cnt), 32'd0);
        start_pulse();
        check_eq("restart_addr", 32'(Address), 32'h2000);
        check_eq("restart_nread", 32'(nRead), 32'h0);
        check_eq("restart_halt", 32'(Halted), 32'h0);

        // Illegal opcode at address 0
        rom[0] = 32'h0800_0000;
        do_reset();
        start_pulse();
        cyc = 0;
        seen_valid = 1'b0;
        while (!Halted && cyc < 20) begin
            tick();
            cyc++;
            if (InstrValid) seen_valid = 1'b1;
        end
        check_eq("ill_halted", 32'(Halted), 32'h1);
        check_eq("ill_flag", 32'(IllegalOp), 32'h1);
        check_eq("ill_novalid", 32'(seen_valid), 32'h0);
        check_eq("ill_cycles", 32'(cyc), 32'd2);
        check_eq("ill_opcode", 32'(Opcode), 32'h08);

        // No stop: wrap from the last word back to address 0
        for (int i = 0; i < 12; i++) rom[i] = {8'(i % 8), 8'(i), 8'h00, 8'h00};
        do_reset();
        start_pulse();
        cyc = 0;
        found = 1'b0;
        while (!found && cyc < 100) begin
            if (InstrValid && Pc == 12'd11) found = 1'b1;
            else begin
                tick();
                cyc++;
            end
        end
        check_eq("wrap_reached", 32'(found), 32'h1);
        tick();
        check_eq("wrap_addr", 32'(Address), 32'h2000);
        check_eq("wrap_pc", 32'(Pc), 32'h0);
        check_eq("wrap_nread", 32'(nRead), 32'h0);
        InstrReady = 1'b0;

        // Reset during ISSUE, with Start held
        do_reset();
        start_pulse();
        tick();
        tick();
        check_eq("ri_valid_pre", 32'(InstrValid), 32'h1);
        nReset = 1'b0;
        Start  = 1'b1;
        tick();
        check_eq("ri_valid", 32'(InstrValid), 32'h0);
        check_eq("ri_pc", 32'(Pc), 32'h0);
        check_eq("ri_addr", 32'(Address), 32'h0000);
        check_eq("ri_fields", {Opcode, Dest, Src1, Src2}, 32'h0);
        check_eq("ri_flags", 32'({nRead, IsMatrix, IsInt, Halted, IllegalOp}), 32'h10);
        tick();
        check_eq("ri_start_ign", 32'({nRead, Address}), 32'h1_0000);

        // Reset during FETCH: strobe released at that edge, nothing captured
        nReset = 1'b1;
        tick();
        Start = 1'b0;
        check_eq("rf_nread_lo", 32'(nRead), 32'h0);
        nReset = 1'b0;
        tick();
        check_eq("rf_nread_hi", 32'(nRead), 32'h1);
        nReset = 1'b1;
        tick();
        tick();
        tick();
        check_eq("rf_no_issue", 32'({InstrValid, Opcode}), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
